// File: rtl/div_pkg.sv
// Shared types for the div_rem restoring divider.
// FSM state encoding and the state enum built on it.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/div_rem_step.sv
// One restoring-division iteration, purely combinational.
// Ports: a_i/x_i/d_i = partial remainder, dividend shift reg, divisor;
//        a_o/x_o = next partial remainder and shift reg (quotient LSB in).
module div_rem_step #(
  parameter int N = 20
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] x_o
);

  // a_i < d_i always holds, so the shifted value fits in N+1 bits
  // and the difference after a successful compare fits in N bits.
  logic [N:0] sh;
  logic [N:0] diff;
  logic       ge;

  assign sh   = {a_i, x_i[N-1]};
  assign ge   = (sh >= {1'b0, d_i});
  assign diff = sh - {1'b0, d_i};
  assign a_o  = ge ? diff[N-1:0] : sh[N-1:0];
  assign x_o  = {x_i[N-2:0], ge};

endmodule

// File: rtl/div_rem.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready in/out.
// Ports: clk, reset (async, active-high); start_valid/start_ready with
//        dividend/divisor; out_valid/out_ready with quotient, remainder,
//        div_by_zero.
// Config: define DIV_REM_SIGNED_EN for two's-complement operands.
module div_rem
  import div_pkg::*;
#(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  x_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;

  logic [N-1:0]  a_d;
  logic [N-1:0]  x_d;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic [N-1:0]  quo_d;
  logic [N-1:0]  rem_d;

  div_rem_step #(.N(N)) u_step (
    .a_i (a_q),
    .x_i (x_q),
    .d_i (d_q),
    .a_o (a_d),
    .x_o (x_d)
  );

`ifdef DIV_REM_SIGNED_EN
  logic negq_q;
  logic negr_q;

  // The most-negative value keeps its bit pattern, which read as
  // unsigned is exactly its magnitude.
  assign dvd_mag = dividend[N-1] ? -dividend : dividend;
  assign dvs_mag = divisor[N-1]  ? -divisor  : divisor;
  // Fix-up is applied on the final iteration's combinational result.
  assign quo_d   = negq_q ? -x_d : x_d;
  assign rem_d   = negr_q ? -a_d : a_d;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_d   = x_d;
  assign rem_d   = a_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_REM_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            if (divisor == '0) begin
              state_q <= DONE;
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              a_q     <= '0;
              x_q     <= dvd_mag;
              d_q     <= dvs_mag;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
`ifdef DIV_REM_SIGNED_EN
              negq_q  <= dividend[N-1] ^ divisor[N-1];
              negr_q  <= dividend[N-1];
`endif
            end
          end
        end
        RUN: begin
          a_q   <= a_d;
          x_q   <= x_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rem.sv
// Directed self-checking bench for div_rem at N=20.
// Define DIV_REM_SIGNED_EN to also exercise the signed build.
module tb_div_rem;

  localparam int N = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errs = 0;
  int checks = 0;

  div_rem #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands on a falling edge; return #1 after the accept edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!start_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("launch ready", start_ready, 1);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid seen", out_valid, 1);
  endtask

  task automatic check_res(input string tag,
                           input logic [N-1:0] q,
                           input logic [N-1:0] r,
                           input logic z);
    chk({tag, " quo"}, quotient, q);
    chk({tag, " rem"}, remainder, r);
    chk({tag, " dbz"}, div_by_zero, z);
  endtask

  // With out_ready high the DONE->IDLE edge follows immediately.
  task automatic consume();
    @(posedge clk);
    #1;
    chk("back to idle", start_ready, 1);
  endtask

  initial begin
    int lat;
    int d;
    logic seen;
    logic [N-1:0] q0;
    logic [N-1:0] r0;

    #2;
    chk("rst quo", quotient, 0);
    chk("rst rem", remainder, 0);
    chk("rst dbz", div_by_zero, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst start_ready", start_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // 25/3: latency N edges after accept
    launch(20'd25, 20'd3);
    wait_out(lat);
    chk("25/3 latency", lat, N);
    check_res("25/3", 20'd8, 20'd1, 1'b0);
    consume();

    launch(20'd14400, 20'd480);
    wait_out(lat);
    check_res("14400/480", 20'd30, 20'd0, 1'b0);
    consume();

    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(999, 1);
      launch(20'd14400, N'(d));
      wait_out(lat);
      check_res("14400/rnd", N'(14400 / d), N'(14400 % d), 1'b0);
      consume();
    end

    // zero divisor goes straight to DONE
    launch(20'd14400, 20'd0);
    wait_out(lat);
    chk("div0 latency", lat, 0);
    check_res("14400/0", 20'hFFFFF, 20'd14400, 1'b1);
    consume();

    launch(20'd14400, 20'd7);
    wait_out(lat);
    check_res("14400/7", 20'd2057, 20'd1, 1'b0);
    consume();

    // backpressure: outputs hold, start_valid ignored
    out_ready = 1'b0;
    launch(20'd100, 20'd7);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      dividend    = 20'd999;
      divisor     = 20'd2;
      @(posedge clk);
      #1;
      check_res("bp hold", 20'd14, 20'd2, 1'b0);
      chk("bp out_valid", out_valid, 1);
      chk("bp start_ready", start_ready, 0);
    end
    @(negedge clk);
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release valid", out_valid, 0);
    chk("bp release ready", start_ready, 1);
    @(posedge clk);
    #1;
    chk("bp no stray accept", start_ready, 1);

    // reset during iteration 10
    launch(20'd14400, 20'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre-abort busy", start_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check_res("abort", 20'd0, 20'd0, 1'b0);
    chk("abort out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort start_ready", start_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no result", seen, 0);

    launch(20'd25, 20'd3);
    wait_out(lat);
    chk("post-abort latency", lat, N);
    check_res("post-abort 25/3", 20'd8, 20'd1, 1'b0);
    consume();

`ifdef DIV_REM_SIGNED_EN
    launch(20'hFFFE7, 20'd3);
    wait_out(lat);
    chk("-25/3 latency", lat, N);
    check_res("-25/3", 20'hFFFF8, 20'hFFFFF, 1'b0);
    consume();

    launch(20'h80000, 20'hFFFFF);
    wait_out(lat);
    check_res("min/-1", 20'h80000, 20'd0, 1'b0);
    consume();

    q0 = 20'hFFFF9;
    r0 = 20'd4;
    launch(20'd46, 20'hFFFFA);
    wait_out(lat);
    check_res("46/-6", q0, r0, 1'b0);
    consume();
`else
    q0 = 20'd1;
    r0 = 20'h7FFFF;
    launch(20'hFFFFF, 20'h80000);
    wait_out(lat);
    check_res("max/half", q0, r0, 1'b0);
    consume();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
